// File: rtl/bounce_generator_if.sv
// Level-in / bouncing-level-out bundle for the contact-bounce emulator.
interface bounce_generator_if;
    logic        clean_in;
    logic        enable;
    logic        bouncy_out;
    logic        busy;
    logic [15:0] edge_count;

    modport master (
        output clean_in, enable,
        input  bouncy_out, busy, edge_count
    );

    modport slave (
        input  clean_in, enable,
        output bouncy_out, busy, edge_count
    );
endinterface

// File: rtl/bounce_generator.sv
// Contact-bounce emulator: replays a clean level as HOLD/GLITCH bursts on each edge.
// Define BOUNCE_GEN_DET_EN for fixed pair count and phase length (no LFSR).
module bounce_generator #(
    parameter int          PAIR_BITS   = 3,
    parameter int          GLITCH_BITS = 4,
    parameter int          MIN_GLITCH  = 16,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          TIMER_W     = 24
) (
    input logic               clk,
    input logic               rst_n,
    bounce_generator_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] GLITCH = 2'd2;

    logic [1:0]           state;
    logic                 target;
    logic                 bouncy;
    logic                 busy_q;
    logic                 edge_det;
    logic [15:0]          edge_cnt;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   draw_len;
    logic [PAIR_BITS-1:0] pairs_left;
    logic [PAIR_BITS-1:0] draw_pairs;

`ifdef BOUNCE_GEN_DET_EN
    assign draw_pairs = '1;
    assign draw_len   = TIMER_W'(MIN_GLITCH - 1);
`else
    localparam logic [15:0] SEED_INIT = (SEED == 16'h0) ? 16'h0001 : SEED;

    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_INIT;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign draw_pairs = lfsr[PAIR_BITS-1:0];
    assign draw_len   = TIMER_W'(MIN_GLITCH - 1)
                      + TIMER_W'(lfsr[PAIR_BITS+GLITCH_BITS-1:PAIR_BITS]);
`endif

    assign edge_det = bus.clean_in != target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= 1'b0;
            bouncy     <= 1'b0;
            busy_q     <= 1'b0;
            edge_cnt   <= 16'd0;
            timer      <= '0;
            pairs_left <= '0;
        end else begin
            if (edge_det) begin
                target   <= bus.clean_in;
                edge_cnt <= edge_cnt + 16'd1;
            end
            if (edge_det && bus.enable) begin
                bouncy     <= bus.clean_in;
                pairs_left <= draw_pairs;
                timer      <= draw_len;
                state      <= HOLD;
                busy_q     <= 1'b1;
            end else if (edge_det || !bus.enable) begin
                // clean_in equals target whenever there is no edge
                bouncy <= bus.clean_in;
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                unique case (state)
                    HOLD: begin
                        if (timer != '0) begin
                            timer <= timer - TIMER_W'(1);
                        end else if (pairs_left == '0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            bouncy <= ~target;
                            timer  <= draw_len;
                            state  <= GLITCH;
                        end
                    end
                    GLITCH: begin
                        if (timer != '0) begin
                            timer <= timer - TIMER_W'(1);
                        end else begin
                            pairs_left <= pairs_left - PAIR_BITS'(1);
                            bouncy     <= target;
                            timer      <= draw_len;
                            state      <= HOLD;
                        end
                    end
                    default: begin
                        bouncy <= target;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.bouncy_out = bouncy;
    assign bus.busy       = busy_q;
    assign bus.edge_count = edge_cnt;
endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator plus a phase-length monitor.
module tb_bounce_generator;
    localparam int PB = 3;
    localparam int GB = 4;
    localparam int MG = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clean = 1'b0;
    logic en = 1'b0;
    int   exp_ec = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bounce_generator_if bus ();
    assign bus.clean_in = clean;
    assign bus.enable   = en;

    bounce_generator #(
        .PAIR_BITS(PB), .GLITCH_BITS(GB), .MIN_GLITCH(MG),
        .SEED(16'hACE1), .TIMER_W(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] s;
        s = {1'b0, v[15:1]};
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    function automatic int exp_len(input logic [15:0] v);
`ifdef BOUNCE_GEN_DET_EN
        return MG + 0 * int'(v[0]);
`else
        return MG + int'(v[PB+GB-1:PB]);
`endif
    endfunction

    function automatic int exp_pairs(input logic [15:0] v);
`ifdef BOUNCE_GEN_DET_EN
        return (1 << PB) - 1 + 0 * int'(v[0]);
`else
        return int'(v[PB-1:0]);
`endif
    endfunction

    // reference LFSR; m_prev holds the value in effect at the last edge
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    bit          mon_on = 0;
    int          cnt = 0, elen = 0, epairs = 0, nglitch = 0;
    logic        last_busy = 1'b0, last_bouncy = 1'b0;
    logic [15:0] last_ec = 16'd0;

    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            if (bus.edge_count != last_ec) begin
                check("edge_busy", bus.busy, 1);
                check("edge_out", bus.bouncy_out, clean);
                epairs  = exp_pairs(m_prev);
                elen    = exp_len(m_prev);
                cnt     = 1;
                nglitch = 0;
            end else if (last_busy && bus.busy && bus.bouncy_out != last_bouncy) begin
                check("phase_len", cnt, elen);
                if (bus.bouncy_out != clean) nglitch++;
                elen = exp_len(m_prev);
                cnt  = 1;
            end else if (last_busy && !bus.busy) begin
                check("phase_len", cnt, elen);
                check("glitch_pairs", nglitch, epairs);
            end else if (bus.busy) begin
                cnt++;
            end
            if (!bus.busy) check("idle_level", bus.bouncy_out, clean);
        end
        last_ec     = bus.edge_count;
        last_busy   = bus.busy;
        last_bouncy = bus.bouncy_out;
    end

    task automatic find_glitch(output bit found);
        found = 0;
        for (int a = 0; a < 6 && !found; a++) begin
            @(negedge clk);
            en = 1'b1;
            clean = !clean;
            exp_ec++;
            for (int k = 0; k < 500 && !found; k++) begin
                @(posedge clk); #1;
                if (bus.bouncy_out != clean) found = 1;
            end
        end
        check("glitch_seen", found, 1);
    endtask

    task automatic run_random(input int n, output logic [31:0] sig);
        sig = 32'd0;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                if (c == 0 || (c == 25 && i % 5 == 3)) begin
                    clean = !clean;
                    exp_ec++;
                end
                @(posedge clk); #1;
                sig = (sig << 5) + sig + {30'd0, bus.bouncy_out, bus.busy};
            end
            check("rnd_done", bus.busy, 0);
            check("rnd_count", bus.edge_count, exp_ec);
        end
    endtask

    task automatic reset_to_idle(input logic en_val);
        mon_on = 0;
        @(negedge clk);
        rst_n = 1'b0;
        clean = 1'b0;
        en = en_val;
        exp_ec = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    bit          found;
    int          hold_n;
    logic [31:0] sig_a, sig_b;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", bus.bouncy_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.edge_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_out", bus.bouncy_out, 0);
        check("idle_count", bus.edge_count, 0);

        // pass-through with enable low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clean = !clean;
            exp_ec++;
            #1;
            check("pt_pre", bus.bouncy_out, !clean);
            @(posedge clk); #1;
            check("pt_out", bus.bouncy_out, clean);
            check("pt_busy", bus.busy, 0);
            repeat (9) @(posedge clk);
        end
        #1;
        check("pt_count", bus.edge_count, 5);

        // enable dropped early in a sequence
        @(negedge clk);
        en = 1'b1;
        clean = 1'b0;
        exp_ec++;
        @(posedge clk); #1;
        check("seq_out", bus.bouncy_out, 0);
        check("seq_busy", bus.busy, 1);
        check("seq_count", bus.edge_count, exp_ec);
        repeat (3) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        check("dis_busy", bus.busy, 0);
        check("dis_out", bus.bouncy_out, clean);

        // enable dropped during a glitch
        find_glitch(found);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        check("dis_g_busy", bus.busy, 0);
        check("dis_g_out", bus.bouncy_out, clean);

        // edge during a glitch restarts the sequence
        find_glitch(found);
        @(negedge clk);
        clean = !clean;
        exp_ec++;
        @(posedge clk); #1;
        check("abort_out", bus.bouncy_out, clean);
        check("abort_busy", bus.busy, 1);
        check("abort_count", bus.edge_count, exp_ec);
        repeat (600) @(posedge clk);
        #1;
        check("abort_done", bus.busy, 0);

        // enable drop and edge in the same cycle
        find_glitch(found);
        @(negedge clk);
        en = 1'b0;
        clean = !clean;
        exp_ec++;
        @(posedge clk); #1;
        check("dis_e_busy", bus.busy, 0);
        check("dis_e_out", bus.bouncy_out, clean);
        check("dis_e_count", bus.edge_count, exp_ec);

        // random sequences, twice from reset
        reset_to_idle(1'b1);
        mon_on = 1;
        run_random(24, sig_a);
        reset_to_idle(1'b1);
        mon_on = 1;
        run_random(24, sig_b);
        mon_on = 0;
        check("repeat_sig", sig_b, sig_a);

        // reset mid-sequence, release with clean_in high
        @(negedge clk);
        clean = !clean;
        repeat (10) @(posedge clk);
        @(negedge clk);
        clean = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_out", bus.bouncy_out, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_count", bus.edge_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_count", bus.edge_count, 1);
        check("rel_out", bus.bouncy_out, 1);
        check("rel_busy", bus.busy, 1);
        // first draw from 16'hACE1: 1 pair, hold of 16+12 cycles
        hold_n = 1;
        while (bus.bouncy_out && hold_n < 100) begin
            @(posedge clk); #1;
            if (bus.bouncy_out) hold_n++;
        end
`ifdef BOUNCE_GEN_DET_EN
        check("rel_hold", hold_n, MG);
`else
        check("rel_hold", hold_n, 28);
`endif
        check("rel_glitch", bus.busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
